packet_receiver: RTL

- Host-side/loopback deframer for the correlator's outbound telemetry packet.
- Takes the byte stream produced by the packet generator and rebuilds the full packet word:
  - header: tick, capability flags, lag and delay sizes, input count, resolution
  - payload: counter/correlation pulses
  - footer: 64-bit timestamp
- Sits behind a uart_rx or spi_slave byte receiver. Used for board-to-board chaining and for self-check of the transmit path.

---
 rtl/packet_receiver.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/packet_receiver.sv
// Deframer for the correlator telemetry packet. It rebuilds header, payload and
// footer from an ASCII-hex (CR-terminated) or a fixed-length raw binary byte stream.
module packet_receiver #(
    parameter int BINARY         = 0,
    parameter int PAYLOAD_SIZE   = 1920,
    parameter int HEADER_SIZE    = 64,
    parameter int FOOTER_SIZE    = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [PAYLOAD_SIZE-1:0] payload,
    output logic [63:0]             timestamp,
    output logic [15:0]             tick,
    output logic [3:0]              flags,
    output logic [7:0]              lag_cross,
    output logic [7:0]              lag_auto,
    output logic [11:0]             delay_size,
    output logic [7:0]              num_inputs,
    output logic [7:0]              resolution,
    output logic                    packet_valid,
    output logic                    frame_error,
    output logic                    busy
);

    localparam int P      = HEADER_SIZE + PAYLOAD_SIZE + FOOTER_SIZE;
    localparam int NUNITS = (BINARY != 0) ? P / 8 : P / 4;
    localparam int CW     = $clog2(NUNITS + 2);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, RECV, SYNC} state_t;

    state_t          state, state_next;
    logic [P-1:0]    sh;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   idle_cnt;

    logic            is_hex, is_cr, is_lf;
    logic [3:0]      nib;
    logic            timeout;
    logic            load_first, load_next, latch, err, go_idle, go_sync;
    logic [P-1:0]    first_word, shifted, frame;
    logic [63:0]     hdr;

    function automatic logic [7:0] plus_one_sat(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + 9'd1;
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
        end
    end

    assign is_cr = (rx_data == 8'h0D);
    assign is_lf = (rx_data == 8'h0A);

    // A byte in the expiry cycle takes priority over the timeout.
    assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !rx_valid &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign first_word = (BINARY != 0) ? P'(rx_data) : P'(nib);
    assign shifted    = (BINARY != 0) ? {sh[P-9:0], rx_data} : {sh[P-5:0], nib};
    // In binary mode the final byte is still on rx_data when the fields latch.
    assign frame      = (BINARY != 0) ? shifted : sh;
    assign hdr        = frame[P-1 -: 64];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (go_idle)         state_next = IDLE;
        else if (go_sync)    state_next = SYNC;
        else if (load_first) state_next = RECV;
    end

    always_comb begin
        load_first = 1'b0;
        load_next  = 1'b0;
        latch      = 1'b0;
        err        = 1'b0;
        go_idle    = 1'b0;
        go_sync    = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (BINARY != 0) begin
                        load_first = 1'b1;
                    end else if (is_hex) begin
                        load_first = 1'b1;
                    end else if (!is_cr && !is_lf) begin
                        err     = 1'b1;
                        go_sync = 1'b1;
                    end
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (BINARY != 0) begin
                        load_next = 1'b1;
                        if (cnt == CW'(NUNITS - 1)) begin
                            latch   = 1'b1;
                            go_idle = 1'b1;
                        end
                    end else if (is_hex) begin
                        if (cnt == CW'(NUNITS)) begin
                            err     = 1'b1;
                            go_sync = 1'b1;
                        end else begin
                            load_next = 1'b1;
                        end
                    end else if (is_cr) begin
                        latch   = (cnt == CW'(NUNITS));
                        err     = (cnt != CW'(NUNITS));
                        go_idle = 1'b1;
                    end else if (!is_lf) begin
                        err     = 1'b1;
                        go_sync = 1'b1;
                    end
                end else if (timeout) begin
                    err     = 1'b1;
                    go_idle = 1'b1;
                end
            end
            SYNC: begin
                // Resynchronising: swallow everything up to CR, never report twice.
                if ((rx_valid && is_cr) || timeout) go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh           <= '0;
            cnt          <= '0;
            idle_cnt     <= '0;
            payload      <= '0;
            timestamp    <= '0;
            tick         <= '0;
            flags        <= '0;
            lag_cross    <= '0;
            lag_auto     <= '0;
            delay_size   <= '0;
            num_inputs   <= '0;
            resolution   <= '0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= latch;
            frame_error  <= err;

            if (rx_valid || state == IDLE || TIMEOUT_CYCLES == 0) idle_cnt <= '0;
            else                                                  idle_cnt <= idle_cnt + TW'(1);

            if (load_first) begin
                sh  <= first_word;
                cnt <= CW'(1);
            end else if (load_next) begin
                sh  <= shifted;
                cnt <= cnt + CW'(1);
            end

            if (latch) begin
                resolution <= hdr[63:56];
                num_inputs <= plus_one_sat(hdr[55:48]);
                delay_size <= hdr[47:36];
                lag_auto   <= plus_one_sat(hdr[35:28]);
                lag_cross  <= plus_one_sat(hdr[27:20]);
                flags      <= hdr[19:16];
                tick       <= hdr[15:0];
                payload    <= frame[FOOTER_SIZE +: PAYLOAD_SIZE];
                timestamp  <= frame[63:0];
            end
        end
    end

endmodule
